// File: rtl/bias_relu_pkg.sv
// Shared definitions for the bias_relu stage: FSM encoding and pipeline depth.
package bias_relu_pkg;

  // Number of register stages between a FIFO pop and valid_out.
  localparam int BR_PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_RUN   = 2'd1,
    BR_DRAIN = 2'd2
  } br_state_e;

endpackage

// File: rtl/bias_relu_lane.sv
// One lane of bias_relu: signed add at DATA_WIDTH+1 bits (stage 2), then
// reduction and optional ReLU registered into the lane result (stage 3).
// Build option: BIAS_RELU_SATURATE_EN selects clamping instead of wrapping.
module bias_relu_lane
  import bias_relu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add_en,
  input  logic                  out_en,
  input  logic                  relu_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH:0]   sum_r;
  logic [DATA_WIDTH-1:0] reduced_s;
  logic [DATA_WIDTH-1:0] relu_s;

  // Bring the widened sum back to DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] reduce_sum(input logic [DATA_WIDTH:0] s);
`ifdef BIAS_RELU_SATURATE_EN
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      if (s[DATA_WIDTH]) begin
        reduce_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        reduce_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      reduce_sum = s[DATA_WIDTH-1:0];
    end
`else
    reduce_sum = s[DATA_WIDTH-1:0];
`endif
  endfunction

  // Stage 2: sign-extended add so overflow is visible in the extra bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r <= '0;
    end else if (add_en) begin
      sum_r <= {data[DATA_WIDTH-1], data} + {bias[DATA_WIDTH-1], bias};
    end else begin
      sum_r <= sum_r;
    end
  end

  // Reduce, then clear negative lanes when ReLU is on.
  always_comb begin
    reduced_s = reduce_sum(sum_r);
    relu_s    = reduced_s;
    if (relu_en && reduced_s[DATA_WIDTH-1]) begin
      relu_s = '0;
    end else begin
      relu_s = reduced_s;
    end
  end

  // Stage 3: result register; holds its value when no group advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (out_en) begin
      result <= relu_s;
    end else begin
      result <= result;
    end
  end

endmodule

// File: rtl/bias_relu.sv
// bias_relu: adds a rotating per-position bias vector to each accumulated
// group, optionally applies ReLU, and forwards over valid/avail.
// Build option: BIAS_RELU_SATURATE_EN (lane sums clamp instead of wrap).
module bias_relu
  import bias_relu_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int GROUP_SIZE    = 4,
  parameter int NUM_BIAS      = 4096,
  parameter int LOG_NUM_BIAS  = 12,
  parameter int LOG_MAX_ITEMS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bias_write,
  input  logic [LOG_NUM_BIAS-1:0]          bias_addr,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] bias_data,
  input  logic                             configure,
  input  logic [LOG_MAX_ITEMS-1:0]         num_items,
  input  logic [LOG_NUM_BIAS-1:0]          num_bias,
  input  logic                             relu_en,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic                             done
);

  localparam int VW = GROUP_SIZE * DATA_WIDTH;

  br_state_e                state_r, next_state_s;
  logic [VW-1:0]            fifo_mem [0:1];
  logic                     wr_ptr_r, rd_ptr_r;
  logic [1:0]               count_r, count_next_s;
  logic                     avail_r;
  logic                     push_s, pop_s, empty_s, full_s;
  logic [VW-1:0]            bias_mem [0:NUM_BIAS-1];
  logic [VW-1:0]            bias_q_r, word_r;
  logic [LOG_MAX_ITEMS-1:0] items_left_r;
  logic [LOG_NUM_BIAS-1:0]  bias_idx_r, num_bias_r;
  logic                     relu_r;
  logic [BR_PIPE_DEPTH-1:0] vpipe_r;
  logic                     done_r, done_next_s;

  assign empty_s   = (count_r == 2'd0);
  assign full_s    = (count_r == 2'd2);
  assign push_s    = valid_in & ~full_s;
  assign avail_out = avail_r;
  assign valid_out = vpipe_r[BR_PIPE_DEPTH-1];
  assign done      = done_r;

  // FIFO occupancy bookkeeping; room is advertised only when empty.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, count and registered avail_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      avail_r  <= 1'b1;
    end else begin
      wr_ptr_r <= push_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r <= pop_s ? ~rd_ptr_r : rd_ptr_r;
      count_r  <= count_next_s;
      avail_r  <= (count_next_s == 2'd0);
    end
  end

  // FIFO storage (no reset needed, guarded by the count).
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_r] <= data_in;
    end
  end

  // Bias memory: writable only while idle.
  always_ff @(posedge clk) begin
    if (bias_write && (state_r == BR_IDLE)) begin
      bias_mem[bias_addr] <= bias_data;
    end
  end

  // Next-state, pop and done decode; configure aborts from any state.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    done_next_s  = 1'b0;
    if (configure) begin
      if (num_items == '0) begin
        next_state_s = BR_IDLE;
        done_next_s  = 1'b1;
      end else begin
        next_state_s = BR_RUN;
      end
    end else begin
      case (state_r)
        BR_IDLE: next_state_s = BR_IDLE;
        BR_RUN: begin
          if (!empty_s && avail_in) begin
            pop_s = 1'b1;
            if (items_left_r == LOG_MAX_ITEMS'(1)) begin
              next_state_s = BR_DRAIN;
            end else begin
              next_state_s = BR_RUN;
            end
          end else begin
            next_state_s = BR_RUN;
          end
        end
        BR_DRAIN: begin
          if (vpipe_r == '0) begin
            next_state_s = BR_IDLE;
            done_next_s  = 1'b1;
          end else begin
            next_state_s = BR_DRAIN;
          end
        end
        default: next_state_s = BR_IDLE;
      endcase
    end
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= BR_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= done_next_s;
    end
  end

  // Configuration latch, item countdown and bias index rotation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      items_left_r <= '0;
      bias_idx_r   <= '0;
      num_bias_r   <= LOG_NUM_BIAS'(1);
      relu_r       <= 1'b0;
    end else if (configure) begin
      items_left_r <= num_items;
      bias_idx_r   <= '0;
      num_bias_r   <= (num_bias == '0) ? LOG_NUM_BIAS'(1) : num_bias;
      relu_r       <= relu_en;
    end else if (pop_s) begin
      items_left_r <= items_left_r - LOG_MAX_ITEMS'(1);
      if (bias_idx_r == num_bias_r - LOG_NUM_BIAS'(1)) begin
        bias_idx_r <= '0;
      end else begin
        bias_idx_r <= bias_idx_r + LOG_NUM_BIAS'(1);
      end
    end else begin
      items_left_r <= items_left_r;
      bias_idx_r   <= bias_idx_r;
    end
  end

  // Pipeline valid shift; an abort flushes everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe_r <= '0;
    end else if (configure) begin
      vpipe_r <= '0;
    end else begin
      vpipe_r <= {vpipe_r[BR_PIPE_DEPTH-2:0], pop_s};
    end
  end

  // Stage 1: registered bias read alongside the popped FIFO word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_q_r <= '0;
      word_r   <= '0;
    end else if (pop_s) begin
      bias_q_r <= bias_mem[bias_idx_r];
      word_r   <= fifo_mem[rd_ptr_r];
    end else begin
      bias_q_r <= bias_q_r;
      word_r   <= word_r;
    end
  end

  for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
    bias_relu_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .add_en (vpipe_r[0]),
      .out_en (vpipe_r[1]),
      .relu_en(relu_r),
      .data   (word_r[g*DATA_WIDTH +: DATA_WIDTH]),
      .bias   (bias_q_r[g*DATA_WIDTH +: DATA_WIDTH]),
      .result (data_out[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_bias_relu.sv
// Self-checking bench for bias_relu (default parameters). Honours
// BIAS_RELU_SATURATE_EN in its reference model and overflow table.
module tb_bias_relu;

  logic        clk = 1'b0;
  logic        rst;
  logic        bias_write;
  logic [11:0] bias_addr;
  logic [31:0] bias_data;
  logic        configure;
  logic [15:0] num_items;
  logic [11:0] num_bias;
  logic        relu_en;
  logic [31:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        avail_in;
  logic        done;

  always #5 clk = ~clk;

  bias_relu dut (
    .clk(clk), .rst(rst), .bias_write(bias_write), .bias_addr(bias_addr),
    .bias_data(bias_data), .configure(configure), .num_items(num_items),
    .num_bias(num_bias), .relu_en(relu_en), .data_in(data_in),
    .valid_in(valid_in), .avail_out(avail_out), .data_out(data_out),
    .valid_out(valid_out), .avail_in(avail_in), .done(done)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] bias_m [0:7];
  int m_nb = 1;
  int m_idx = 0;
  bit m_relu = 1'b0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          relu;
    logic [31:0] exp;
  } ov_t;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && valid_out) got_q.push_back(data_out);
    if (rst && done) done_cnt <= done_cnt + 1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] vec(int a, int b, int c, int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  // Reference: per-lane signed sum, reduced, then ReLU.
  function automatic logic [31:0] model(logic [31:0] d, logic [31:0] b, bit relu);
    logic [31:0] r;
    logic [7:0]  dl, bl;
    int x, y, s;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      dl = d[8*i +: 8];
      bl = b[8*i +: 8];
      x = $signed(dl);
      y = $signed(bl);
      s = x + y;
`ifdef BIAS_RELU_SATURATE_EN
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
`else
      s = ((s + 128) & 255) - 128;
`endif
      if (relu && s < 0) s = 0;
      r[8*i +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbias(int a, logic [31:0] d, bit track);
    bias_write = 1'b1; bias_addr = a[11:0]; bias_data = d;
    tick();
    bias_write = 1'b0;
    if (track) bias_m[a] = d;
  endtask

  task automatic cfg(int n, int nb, bit r);
    configure = 1'b1; num_items = n[15:0]; num_bias = nb[11:0]; relu_en = r;
    tick();
    configure = 1'b0;
    m_nb = (nb == 0) ? 1 : nb;
    m_relu = r;
    m_idx = 0;
  endtask

  task automatic push_raw(logic [31:0] d);
    valid_in = 1'b1; data_in = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_avail(string nm);
    int k = 0;
    while (!avail_out && k < 200) begin tick(); k++; end
    if (k >= 200) check({nm, "_avail_timeout"}, 32'd0, 32'd1);
  endtask

  // Push one group and predict its result.
  task automatic feed(logic [31:0] d);
    wait_avail("feed");
    push_raw(d);
    exp_q.push_back(model(d, bias_m[m_idx], m_relu));
    m_idx = (m_idx + 1) % m_nb;
  endtask

  task automatic wait_done(int d0, string nm);
    int k = 0;
    while (done_cnt == d0 && k < 400) begin tick(); k++; end
    repeat (4) tick();
    check({nm, "_done_count"}, done_cnt - d0, 32'd1);
  endtask

  task automatic compare_stream(string nm);
    check({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_item%0d", nm, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Backpressure window: avail_in low for 10 cycles.
  task automatic drop_avail();
    int cnt_all = 0, cnt_late = 0;
    repeat (12) tick();
    avail_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out) begin
        cnt_all++;
        if (i >= 3) cnt_late++;
      end
    end
    avail_in = 1'b1;
    check("bp_inflight_le3", (cnt_all <= 3), 32'd1);
    check("bp_no_pop_during_drop", cnt_late, 32'd0);
  endtask

  task automatic random_run(int n, int nb, bit r, string nm);
    int d0;
    for (int a = 0; a < 3; a++) wbias(a, $urandom(), 1'b1);
    d0 = done_cnt;
    cfg(n, nb, r);
    fork
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        feed($urandom());
      end
      drop_avail();
    join
    wait_done(d0, nm);
    compare_stream(nm);
  endtask

  vec_t tbl[4];
  ov_t  ov_tbl[2];
  int   d0, k;
  logic [31:0] a_w, b_w;

  initial begin
    rst = 1'b0; bias_write = 1'b0; bias_addr = '0; bias_data = '0;
    configure = 1'b0; num_items = '0; num_bias = '0; relu_en = 1'b0;
    data_in = '0; valid_in = 1'b0; avail_in = 1'b1;
    for (int i = 0; i < 8; i++) bias_m[i] = 32'd0;

    tbl[0] = '{vec(10, -5, 0, 7), vec(14, 0, 2, 8)};
    tbl[1] = '{vec(10, -5, 0, 7), vec(9, 0, 0, 6)};
    tbl[2] = '{vec(10, -5, 0, 7), vec(14, 0, 2, 8)};
    tbl[3] = '{vec(10, -5, 0, 7), vec(9, 0, 0, 6)};
`ifdef BIAS_RELU_SATURATE_EN
    ov_tbl[0] = '{1'b0, 32'h7f7f7f7f};
    ov_tbl[1] = '{1'b1, 32'h7f7f7f7f};
`else
    ov_tbl[0] = '{1'b0, 32'h8c8c8c8c};
    ov_tbl[1] = '{1'b1, 32'h00000000};
`endif

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("reset_valid_out", valid_out, 32'd0);
    check("reset_done", done, 32'd0);
    check("reset_data_out", data_out, 32'd0);
    check("reset_avail_out", avail_out, 32'd1);

    // Bias rotation table, with pop-to-output latency on the first group
    wbias(0, vec(4, 3, 2, 1), 1'b1);
    wbias(1, vec(-1, -1, -1, -1), 1'b1);
    d0 = done_cnt;
    cfg(4, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_avail("rot");
      push_raw(tbl[i].din);
      if (i == 0) begin
        k = 0;
        while (!valid_out && k < 10) begin tick(); k++; end
        check("latency_write_to_valid", k, 32'd3);
      end
    end
    wait_done(d0, "rot");
    check("rot_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("rot_item%0d", i), got_q[i], tbl[i].exp);
    got_q.delete();

    // Overflow table
    wbias(0, vec(20, 20, 20, 20), 1'b1);
    for (int i = 0; i < 2; i++) begin
      d0 = done_cnt;
      cfg(1, 1, ov_tbl[i].relu);
      wait_avail("ov");
      push_raw(vec(120, 120, 120, 120));
      wait_done(d0, "ov");
      check("ov_count", got_q.size(), 32'd1);
      if (got_q.size() > 0) check($sformatf("ov_relu%0d", i), got_q[0], ov_tbl[i].exp);
      got_q.delete();
    end

    // num_items = 0: done exactly one cycle later, no output
    d0 = done_cnt;
    cfg(0, 1, 1'b0);
    check("zero_items_done_next", done, 32'd1);
    tick();
    check("zero_items_done_low", done, 32'd0);
    repeat (5) tick();
    check("zero_items_no_output", got_q.size(), 32'd0);
    check("zero_items_one_done", done_cnt - d0, 32'd1);

    // bias_write during RUN is ignored
    wbias(0, vec(5, 5, 5, 5), 1'b1);
    d0 = done_cnt;
    cfg(1, 1, 1'b0);
    wbias(0, vec(99, 99, 99, 99), 1'b0);
    feed(vec(1, 2, 3, 4));
    wait_done(d0, "runwr");
    compare_stream("runwr");
    d0 = done_cnt;
    cfg(1, 1, 1'b0);
    feed(vec(-3, 9, 0, 100));
    wait_done(d0, "runwr2");
    compare_stream("runwr2");

    // FIFO fill in IDLE: two words held, third dropped
    a_w = $urandom(); b_w = $urandom();
    push_raw(a_w);
    push_raw(b_w);
    check("fifo_full_avail_low", avail_out, 32'd0);
    push_raw($urandom());
    d0 = done_cnt;
    cfg(2, 1, 1'b0);
    exp_q.push_back(model(a_w, bias_m[0], 1'b0));
    exp_q.push_back(model(b_w, bias_m[0], 1'b0));
    wait_done(d0, "fifo");
    compare_stream("fifo");

    // Randomized runs with a backpressure window
    random_run(24, 3, $urandom_range(0, 1), "rand1");
    random_run(12, 0, 1'b1, "rand_nb0");

    // Abort: configure while a group is in flight
    d0 = done_cnt;
    cfg(5, 1, 1'b0);
    push_raw($urandom());
    tick();
    cfg(1, 1, 1'b1);
    repeat (6) tick();
    check("abort_no_stale", got_q.size(), 32'd0);
    check("abort_no_done", done_cnt - d0, 32'd0);
    feed(vec(-7, 50, -1, 3));
    wait_done(d0, "abort");
    compare_stream("abort");

    // Asynchronous reset mid-run with two groups in flight
    cfg(4, 1, 1'b0);
    push_raw($urandom());
    wait_avail("rst");
    push_raw($urandom());
    k = 0;
    while (!valid_out && k < 20) begin tick(); k++; end
    check("rst_saw_valid", valid_out, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_async_valid_out", valid_out, 32'd0);
    check("rst_async_data_out", data_out, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    d0 = done_cnt;
    repeat (8) tick();
    check("rst_no_done", done_cnt - d0, 32'd0);
    check("rst_no_output", got_q.size(), 32'd0);
    check("rst_avail_out", avail_out, 32'd1);
    wbias(0, vec(7, 7, 7, 7), 1'b1);
    d0 = done_cnt;
    cfg(1, 1, 1'b0);
    feed(vec(1, -20, 3, 4));
    wait_done(d0, "post_rst");
    compare_stream("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bias_relu.md
Name: bias_relu

Overview:
- Downstream neighbour of the accumulator stage. Consumes final accumulated groups of GROUP_SIZE signed DATA_WIDTH values.
- Adds a per-position bias vector held in a local bias memory, then optionally applies ReLU.
- Forwards results over the codebase valid/avail handshake to the next stage (pooling/writer).
- Bias index rotates across the group stream, matching the per-iteration address sequence of the upstream accumulator.

Parameters:
- DATA_WIDTH, 8, element width; output width equals input width.
- GROUP_SIZE, 4, elements per group.
- NUM_BIAS, 4096, bias memory entries.
- LOG_NUM_BIAS, 12, bias address bits.
- LOG_MAX_ITEMS, 16, bits of the item counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- bias_write  in  1  BIAS interface: write strobe
- bias_addr  in  LOG_NUM_BIAS  BIAS interface: write address
- bias_data  in  GROUP_SIZE*DATA_WIDTH  BIAS interface: bias vector
- configure  in  1  CONFIGURE interface: start pulse
- num_items  in  LOG_MAX_ITEMS  CONFIGURE interface: groups to process
- num_bias  in  LOG_NUM_BIAS  CONFIGURE interface: bias rotation length
- relu_en  in  1  CONFIGURE interface: enable ReLU
- data_in  in  GROUP_SIZE*DATA_WIDTH  IN interface: data
- valid_in  in  1  IN interface: valid
- avail_out  out  1  IN interface: room available
- data_out  out  GROUP_SIZE*DATA_WIDTH  OUT interface: data
- valid_out  out  1  OUT interface: valid
- avail_in  in  1  OUT interface: downstream room
- done  out  1  one-cycle pulse when all items have been emitted

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counters, pipeline valids, data_out, valid_out and done all 0. The input FIFO is emptied, so avail_out=1 once rst is released.
- Input buffering: the existing 2-slot FIFO is written whenever valid_in=1. avail_out = ~full & ~almost_full. Writes while full are the upstream's fault and are dropped.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - bias_write stores bias_data at bias_addr.
  - configure latches num_items, num_bias (0 treated as 1) and relu_en, and clears bias_idx.
  - If num_items=0, done pulses the next cycle and the FSM stays in IDLE; otherwise it goes to RUN.
- RUN:
  - Pop when ~empty & avail_in; items_left decrements on each pop.
  - bias_idx increments on each pop and wraps to 0 after num_bias-1.
  - The pop that takes items_left to 0 moves the FSM to DRAIN.
  - bias_write is ignored in RUN and DRAIN.
- DRAIN: when all pipeline valids are 0, pulse done for one cycle and go to IDLE.
- configure in RUN/DRAIN: aborts. Pipeline valids and counters are cleared, the FIFO contents are kept, and the new configuration is taken as in IDLE.
- Pipeline (3 stages):
  - S1: registered bias memory read at bias_idx; the FIFO word is captured.
  - S2: per-lane signed add.
  - S3: ReLU (lane<0 becomes 0 when relu_en=1), registered into data_out.
  - valid_out is asserted 3 cycles after the pop cycle.
- Backpressure: avail_in gates only new pops. Up to 3 in-flight groups still emerge after avail_in falls, which is the codebase avail contract (the downstream FIFO absorbs pipeline depth).
- data_out: holds its last value when valid_out=0.
- Arithmetic:
  - Two's-complement, DATA_WIDTH per lane, no cross-lane carry. Lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
  - The add is computed at DATA_WIDTH+1 bits, then reduced per the optional feature.

Optional Feature:
- Macro BIAS_RELU_SATURATE_EN.
- Defined: the lane sum clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: the lane sum wraps modulo 2^DATA_WIDTH (low DATA_WIDTH bits kept).
- ReLU is applied after either reduction.

Decomposition:
- Shared package RTLinf.vh:
  - FSM state encoding: BR_IDLE=2'd0, BR_RUN=2'd1, BR_DRAIN=2'd2.
  - BR_PIPE_DEPTH=3.
- Sub-module bias_relu_lane, instantiated GROUP_SIZE times via generate: one lane's add, reduce and ReLU, registered.
- Reuse the existing FIFO and MEM modules; no new memory primitive.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → valid_out=0, done=0, data_out=0, avail_out=1.
- Bias rotation:
  - Setup: bias[0]={4,3,2,1}, bias[1]={-1,-1,-1,-1}; configure num_items=4, num_bias=2, relu_en=1.
  - Stimulus: feed {10,-5,0,7} four times with avail_in=1.
  - Outputs in order: {14,0,2,8}, {9,0,0,6}, {14,0,2,8}, {9,0,0,6}. Each appears 3 cycles after its pop; done pulses once after the last.
- Overflow, with bias[0]={20,20,20,20}, relu_en=0, input {120,...}:
  - With BIAS_RELU_SATURATE_EN defined → {127,127,127,127}.
  - Without it → {-116,...}; with relu_en=1 that becomes {0,...}.
- Backpressure:
  - Drop avail_in mid-stream for 10 cycles → no pops during the drop, at most 3 valid_out after the drop.
  - Resume → no loss or duplication, order preserved. avail_out falls when the FIFO holds 2 words.
- Edge cases:
  - configure num_items=0 → done high exactly 1 cycle later, no valid_out.
  - bias_write during RUN → memory unchanged, verified on the next configure.
- Reset and abort:
  - Assert rst mid-RUN with 2 items in flight → valid_out=0 immediately (asynchronous), no done; after release the FSM is in IDLE.
  - configure during RUN → restart with the new num_items, no stale valid_out.
